// File: rtl/lbist_sched_if.sv
// LBIST engine handshake bundle: start/config toward the engine, done/signature back.
// The master side is the scheduler; the slave side is the LBIST engine.
interface lbist_sched_if;
  logic        lbist_start;
  logic [15:0] cfg_lbist_pat;
  logic [15:0] cfg_chain_depth;
  logic        core_srst;
  logic        lbist_done;
  logic [31:0] lbist_sig;

  modport master (
    output lbist_start,
    output cfg_lbist_pat,
    output cfg_chain_depth,
    output core_srst,
    input  lbist_done,
    input  lbist_sig
  );

  modport slave (
    input  lbist_start,
    input  cfg_lbist_pat,
    input  cfg_chain_depth,
    input  core_srst,
    output lbist_done,
    output lbist_sig
  );
endinterface

// File: rtl/lbist_sched.sv
// LBIST session scheduler: walks a table of NUM_SESS sessions, launches the LBIST engine
// for every enabled slot, compares each signature against its golden value and reports
// per-session and overall pass/fail. Abort and (optionally) a per-session watchdog send
// the engine through a 2-cycle software reset.
// Build option: define LBIST_SCHED_TIMEOUT_EN to include the WAIT_DONE watchdog.
module lbist_sched #(
  parameter int NUM_SESS = 4,
  parameter int SIDX_W   = 2
) (
  input  logic                     mclk,
  input  logic                     srst,
  input  logic                     sched_start,
  input  logic                     sched_abort,
  input  logic [NUM_SESS-1:0]      cfg_sess_en,
  input  logic [16*NUM_SESS-1:0]   cfg_pat,
  input  logic [16*NUM_SESS-1:0]   cfg_depth,
  input  logic [32*NUM_SESS-1:0]   cfg_gold_sig,
  input  logic [23:0]              cfg_timeout,
  lbist_sched_if.master            eng,
  output logic                     sched_busy,
  output logic                     sched_done,
  output logic                     sched_pass,
  output logic                     sched_abort_flag,
  output logic [NUM_SESS-1:0]      sess_fail,
  output logic [NUM_SESS-1:0]      sess_tmo,
  output logic [SIDX_W-1:0]        cur_sess
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StWaitDone, StCheck, StNext, StCoreRst, StFinish
  } state_e;

  localparam logic [SIDX_W-1:0] LastSess = SIDX_W'(NUM_SESS - 1);

  state_e              state_q, state_d;
  logic                start_q, done_q;
  logic [SIDX_W-1:0]   sess_q, sess_d;
  logic [NUM_SESS-1:0] fail_q, fail_d;
  logic                sdone_q, sdone_d;
  logic                pass_q, pass_d;
  logic                abort_q, abort_d;
  logic [15:0]         pat_q, pat_d;
  logic [15:0]         depth_q, depth_d;
  logic                rst_cnt_q, rst_cnt_d;
  logic                start_edge, done_edge, abort_go;

`ifdef LBIST_SCHED_TIMEOUT_EN
  logic [NUM_SESS-1:0] tmo_q, tmo_d;
  logic [23:0]         wd_q, wd_d;
  logic                tmo_hit;

  // Fires on the cfg_timeout-th WAIT_DONE cycle; zero limit disables the watchdog.
  assign tmo_hit  = (cfg_timeout != 24'd0) && ((wd_q + 24'd1) == cfg_timeout);
  assign sess_tmo = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
  assign sess_tmo       = '0;
`endif

  assign start_edge = sched_start & ~start_q;
  assign done_edge  = eng.lbist_done & ~done_q;

  // Abort is honoured everywhere but IDLE and CORE_RST; an already-aborted FINISH is
  // not re-aborted so a held abort level cannot loop FINISH <-> CORE_RST.
  assign abort_go = sched_abort && (state_q != StIdle) && (state_q != StCoreRst) &&
                    !((state_q == StFinish) && abort_q);

  // Next-state and register-update decode.
  always_comb begin
    state_d   = state_q;
    sess_d    = sess_q;
    fail_d    = fail_q;
    sdone_d   = sdone_q;
    pass_d    = pass_q;
    abort_d   = abort_q;
    pat_d     = pat_q;
    depth_d   = depth_q;
    rst_cnt_d = 1'b0;
`ifdef LBIST_SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    wd_d      = wd_q;
`endif
    if (abort_go) begin
      // Abort wins over a same-cycle done edge, mismatch or timeout.
      abort_d = 1'b1;
      state_d = StCoreRst;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            fail_d  = '0;
            sdone_d = 1'b0;
            pass_d  = 1'b0;
            abort_d = 1'b0;
            sess_d  = '0;
`ifdef LBIST_SCHED_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = StLoad;
          end
        end
        StLoad: begin
          if (!cfg_sess_en[sess_q]) begin
            state_d = StNext;
          end else begin
            pat_d   = cfg_pat[16*sess_q +: 16];
            depth_d = cfg_depth[16*sess_q +: 16];
`ifdef LBIST_SCHED_TIMEOUT_EN
            wd_d    = '0;
`endif
            state_d = StStart;
          end
        end
        StStart: state_d = StWaitDone;
        StWaitDone: begin
`ifdef LBIST_SCHED_TIMEOUT_EN
          wd_d = wd_q + 24'd1;
`endif
          // Only a fresh rising edge counts; a level left over from the last session is ignored.
          if (done_edge) begin
            state_d = StCheck;
          end
`ifdef LBIST_SCHED_TIMEOUT_EN
          else if (tmo_hit) begin
            fail_d[sess_q] = 1'b1;
            tmo_d[sess_q]  = 1'b1;
            state_d        = StCoreRst;
          end
`endif
        end
        StCheck: begin
          if (eng.lbist_sig != cfg_gold_sig[32*sess_q +: 32]) begin
            fail_d[sess_q] = 1'b1;
          end
          state_d = StNext;
        end
        StNext: begin
          if (sess_q == LastSess) begin
            state_d = StFinish;
          end else begin
            sess_d  = sess_q + SIDX_W'(1);
            state_d = StLoad;
          end
        end
        StCoreRst: begin
          if (rst_cnt_q) begin
            state_d = abort_q ? StFinish : StNext;
          end else begin
            rst_cnt_d = 1'b1;
          end
        end
        StFinish: begin
          sdone_d = 1'b1;
          pass_d  = ~|fail_q & ~abort_q;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge mclk) begin
    if (srst) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      sess_q    <= '0;
      fail_q    <= '0;
      sdone_q   <= 1'b0;
      pass_q    <= 1'b0;
      abort_q   <= 1'b0;
      pat_q     <= '0;
      depth_q   <= '0;
      rst_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= sched_start;
      done_q    <= eng.lbist_done;
      sess_q    <= sess_d;
      fail_q    <= fail_d;
      sdone_q   <= sdone_d;
      pass_q    <= pass_d;
      abort_q   <= abort_d;
      pat_q     <= pat_d;
      depth_q   <= depth_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

`ifdef LBIST_SCHED_TIMEOUT_EN
  // Watchdog counter and per-session timeout flags.
  always_ff @(posedge mclk) begin
    if (srst) begin
      tmo_q <= '0;
      wd_q  <= '0;
    end else begin
      tmo_q <= tmo_d;
      wd_q  <= wd_d;
    end
  end
`endif

  assign eng.lbist_start     = (state_q == StStart) || (state_q == StWaitDone);
  assign eng.core_srst       = (state_q == StCoreRst);
  assign eng.cfg_lbist_pat   = pat_q;
  assign eng.cfg_chain_depth = depth_q;
  assign sched_busy          = (state_q != StIdle);
  assign sched_done          = sdone_q;
  assign sched_pass          = pass_q;
  assign sched_abort_flag    = abort_q;
  assign sess_fail           = fail_q;
  assign cur_sess            = sess_q;

endmodule

// File: tb/tb_lbist_sched.sv
// Directed bench for lbist_sched with a small behavioural LBIST engine model.
module tb_lbist_sched;
  localparam int NS = 4;

  logic          mclk = 1'b0;
  logic          srst, sched_start, sched_abort;
  logic [NS-1:0] cfg_sess_en;
  logic [16*NS-1:0] cfg_pat, cfg_depth;
  logic [32*NS-1:0] cfg_gold_sig;
  logic [23:0]   cfg_timeout;
  logic          sched_busy, sched_done, sched_pass, sched_abort_flag;
  logic [NS-1:0] sess_fail, sess_tmo;
  logic [1:0]    cur_sess;

  always #5 mclk = ~mclk;

  lbist_sched_if ifc ();

  lbist_sched #(.NUM_SESS(NS), .SIDX_W(2)) dut (
    .mclk             (mclk),
    .srst             (srst),
    .sched_start      (sched_start),
    .sched_abort      (sched_abort),
    .cfg_sess_en      (cfg_sess_en),
    .cfg_pat          (cfg_pat),
    .cfg_depth        (cfg_depth),
    .cfg_gold_sig     (cfg_gold_sig),
    .cfg_timeout      (cfg_timeout),
    .eng              (ifc),
    .sched_busy       (sched_busy),
    .sched_done       (sched_done),
    .sched_pass       (sched_pass),
    .sched_abort_flag (sched_abort_flag),
    .sess_fail        (sess_fail),
    .sess_tmo         (sess_tmo),
    .cur_sess         (cur_sess)
  );

  // Engine model: slot identified from the low bits of the loaded pattern count.
  int          lat = 4;
  logic [3:0]  hang = 4'b0000;
  logic [31:0] eng_sig [NS];
  logic        st_q = 1'b0;
  int          cnt = 0;
  logic [1:0]  slot = 2'd0;
  logic        eng_done = 1'b0;
  logic [31:0] sig_q = '0;
  int          pulses = 0;
  int          crst_cycles = 0;
  logic        stale_mode = 1'b0;
  logic        stale_lvl = 1'b0;

  assign ifc.lbist_done = stale_mode ? stale_lvl : eng_done;
  assign ifc.lbist_sig  = stale_mode ? eng_sig[0] : sig_q;

  always @(posedge mclk) begin
    st_q <= ifc.lbist_start;
    if (ifc.core_srst) crst_cycles <= crst_cycles + 1;
    if (srst || ifc.core_srst) begin
      cnt      <= 0;
      eng_done <= 1'b0;
    end else if (ifc.lbist_start && !st_q) begin
      pulses   <= pulses + 1;
      eng_done <= 1'b0;
      cnt      <= lat;
      slot     <= ifc.cfg_lbist_pat[1:0];
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !hang[slot]) begin
        eng_done <= 1'b1;
        sig_q    <= eng_sig[slot];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int p0 = 0;
  int c0 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_gold();
    for (int i = 0; i < NS; i++) cfg_gold_sig[32*i +: 32] = eng_sig[i];
  endtask

  task automatic pulse_start();
    @(negedge mclk);
    sched_start = 1'b1;
    @(negedge mclk);
    sched_start = 1'b0;
  endtask

  task automatic launch(input logic [NS-1:0] mask);
    cfg_sess_en = mask;
    p0 = pulses;
    c0 = crst_cycles;
    pulse_start();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(sched_done && !sched_busy) && n < 2000) begin
      @(negedge mclk);
      n++;
    end
    check_eq({tag, "_done"}, 32'(sched_done), 32'd1);
  endtask

  task automatic wait_start_sess(input string tag, input logic [1:0] s);
    int n = 0;
    while (!(ifc.lbist_start && cur_sess == s) && n < 2000) begin
      @(negedge mclk);
      n++;
    end
    check_eq({tag, "_started"}, 32'(ifc.lbist_start), 32'd1);
  endtask

  initial begin
    srst = 1'b1; sched_start = 1'b0; sched_abort = 1'b0;
    cfg_sess_en = '0; cfg_timeout = 24'd0; cfg_gold_sig = '0;
    for (int i = 0; i < NS; i++) begin
      cfg_pat[16*i +: 16]   = 16'h0100 + 16'(i);
      cfg_depth[16*i +: 16] = 16'h0200 + 16'(i);
      eng_sig[i]            = 32'hC0DE_0000 + 32'(i * 17);
    end
    set_gold();
    repeat (3) @(negedge mclk);

    // Reset state
    check_eq("rst_busy",  32'(sched_busy), 32'd0);
    check_eq("rst_done",  32'(sched_done), 32'd0);
    check_eq("rst_pass",  32'(sched_pass), 32'd0);
    check_eq("rst_start", 32'(ifc.lbist_start), 32'd0);
    check_eq("rst_csrst", 32'(ifc.core_srst), 32'd0);
    check_eq("rst_fail",  32'(sess_fail), 32'd0);
    srst = 1'b0;
    @(negedge mclk);

    // Matching run, with an extra start edge while busy that must be ignored
    launch(4'b1111);
    repeat (10) @(negedge mclk);
    check_eq("match_busy", 32'(sched_busy), 32'd1);
    pulse_start();
    wait_idle("match");
    check_eq("match_pulses", 32'(pulses - p0), 32'd4);
    check_eq("match_pass",   32'(sched_pass), 32'd1);
    check_eq("match_fail",   32'(sess_fail), 32'd0);
    check_eq("match_tmo",    32'(sess_tmo), 32'd0);
    check_eq("match_abort",  32'(sched_abort_flag), 32'd0);

    // Mismatch on slot 2 with slots 1 and 3 skipped
    cfg_gold_sig[32*2 +: 32] = 32'h1234_5678;
    eng_sig[2] = 32'hDEAD_BEEF;
    launch(4'b0101);
    wait_idle("mis");
    check_eq("mis_pulses", 32'(pulses - p0), 32'd2);
    check_eq("mis_fail",   32'(sess_fail), 32'h4);
    check_eq("mis_pass",   32'(sched_pass), 32'd0);
    eng_sig[2] = 32'hC0DE_0000 + 32'(2 * 17);
    set_gold();

    // All sessions disabled: 4 LOAD/NEXT pairs then FINISH, no engine start
    launch(4'b0000);
    repeat (8) @(negedge mclk);
    check_eq("zero_done_early", 32'(sched_done), 32'd0);
    check_eq("zero_busy",       32'(sched_busy), 32'd1);
    @(negedge mclk);
    check_eq("zero_done",   32'(sched_done), 32'd1);
    check_eq("zero_pass",   32'(sched_pass), 32'd1);
    check_eq("zero_pulses", 32'(pulses - p0), 32'd0);

    // Stale done level must not complete the session
    stale_mode = 1'b1;
    stale_lvl  = 1'b1;
    repeat (2) @(negedge mclk);
    launch(4'b0001);
    repeat (20) @(negedge mclk);
    check_eq("stale_waiting", 32'(ifc.lbist_start), 32'd1);
    check_eq("stale_nodone",  32'(sched_done), 32'd0);
    stale_lvl = 1'b0;
    @(negedge mclk);
    stale_lvl = 1'b1;
    wait_idle("stale");
    check_eq("stale_pass", 32'(sched_pass), 32'd1);
    stale_mode = 1'b0;

    // Abort during slot 0
    lat = 40;
    launch(4'b1111);
    wait_start_sess("abort", 2'd0);
    repeat (3) @(negedge mclk);
    sched_abort = 1'b1;
    @(negedge mclk);
    sched_abort = 1'b0;
    check_eq("abort_lstart_low", 32'(ifc.lbist_start), 32'd0);
    check_eq("abort_csrst_on",   32'(ifc.core_srst), 32'd1);
    wait_idle("abort");
    check_eq("abort_csrst_cycles", 32'(crst_cycles - c0), 32'd2);
    check_eq("abort_flag",   32'(sched_abort_flag), 32'd1);
    check_eq("abort_pass",   32'(sched_pass), 32'd0);
    check_eq("abort_pulses", 32'(pulses - p0), 32'd1);
    lat = 4;

    // Synchronous reset in the middle of slot 1's WAIT_DONE
    launch(4'b1111);
    wait_start_sess("srst", 2'd1);
    @(negedge mclk);
    check_eq("srst_pat_pre",   32'(ifc.cfg_lbist_pat), 32'h0101);
    check_eq("srst_depth_pre", 32'(ifc.cfg_chain_depth), 32'h0201);
    srst = 1'b1;
    @(negedge mclk);
    check_eq("srst_busy",  32'(sched_busy), 32'd0);
    check_eq("srst_start", 32'(ifc.lbist_start), 32'd0);
    check_eq("srst_sess",  32'(cur_sess), 32'd0);
    check_eq("srst_pat",   32'(ifc.cfg_lbist_pat), 32'd0);
    check_eq("srst_depth", 32'(ifc.cfg_chain_depth), 32'd0);
    check_eq("srst_done",  32'(sched_done), 32'd0);
    srst = 1'b0;
    @(negedge mclk);

`ifdef LBIST_SCHED_TIMEOUT_EN
    // Watchdog: slot 1 never completes
    cfg_timeout = 24'd100;
    hang = 4'b0010;
    launch(4'b1111);
    wait_idle("tmo");
    check_eq("tmo_flags",   32'(sess_tmo), 32'h2);
    check_eq("tmo_fail",    32'(sess_fail), 32'h2);
    check_eq("tmo_csrst",   32'(crst_cycles - c0), 32'd2);
    check_eq("tmo_pulses",  32'(pulses - p0), 32'd4);
    check_eq("tmo_pass",    32'(sched_pass), 32'd0);
    check_eq("tmo_abort",   32'(sched_abort_flag), 32'd0);
    hang = 4'b0000;
    cfg_timeout = 24'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
